// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: binary-search controller driving a magnitude comparator to locate an unknown target
module sar_search_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       iter_count
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, guess_q, guess_d, result_q, result_d;
  logic found_q, found_d, err_q, err_d;
  logic [4:0] iter_q, iter_d;
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h);
    return WIDTH'({1'b0, l} + (({1'b0, h} - {1'b0, l}) >> 1));
  endfunction
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    iter_d   = iter_q;
    case (state_q)
      IDLE: if (start) begin
        lo_d     = '0;
        hi_d     = MAX;
        guess_d  = mid('0, MAX);
        found_d  = 1'b0;
        err_d    = 1'b0;
        result_d = '0;
        iter_d   = '0;
        state_d  = SEARCH;
      end
      SEARCH: begin
        iter_d = iter_q + 5'd1;
        if (!$onehot({cmp_gt, cmp_lt, cmp_eq})) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = DONE;
        end else if (cmp_eq) begin
          found_d  = 1'b1;
          result_d = guess_q;
          state_d  = DONE;
        end else if ((cmp_gt && guess_q == hi_q) || (cmp_lt && guess_q == lo_q)) begin
          state_d = DONE;
        end else begin
          // end-of-range checks above guarantee these never wrap
          lo_d    = cmp_gt ? guess_q + WIDTH'(1) : lo_q;
          hi_d    = cmp_lt ? guess_q - WIDTH'(1) : hi_q;
          guess_d = mid(lo_d, hi_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= MAX;
      guess_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
      iter_q   <= iter_d;
    end
  end
  assign guess      = guess_q;
  assign busy       = state_q == SEARCH;
  assign done       = state_q == DONE;
  assign found      = found_q;
  assign err        = err_q;
  assign result     = result_q;
  assign iter_count = iter_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: scoreboard bench for sar_search_ctrl with a behavioural comparator and flag overrides
module tb_sar_search_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic cmp_gt, cmp_lt, cmp_eq, busy, done, found, err;
  logic [15:0] guess, result;
  logic [4:0] iter_count;
  logic [15:0] target = '0;
  int mode = 0;
  typedef struct packed {logic found; logic err; logic [15:0] result; logic [4:0] iter;} res_t;
  res_t sb[$];
  logic [15:0] gq[$];
  int tests = 0, fails = 0, done_cnt = 0;

  always #5 clk = ~clk;

  sar_search_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .guess(guess), .busy(busy), .done(done), .found(found), .err(err), .result(result),
    .iter_count(iter_count)
  );

  // mode 0: ideal comparator, 1: stuck lt, 2: no flags, 3: gt+lt on the 4th compare
  always_comb begin
    {cmp_gt, cmp_lt, cmp_eq} = {target > guess, target < guess, target == guess};
    if (mode == 1) {cmp_gt, cmp_lt, cmp_eq} = 3'b010;
    else if (mode == 2) {cmp_gt, cmp_lt, cmp_eq} = 3'b000;
    else if (mode == 3 && iter_count == 5'd3) {cmp_gt, cmp_lt, cmp_eq} = 3'b110;
  end

  always @(negedge clk) begin
    if (busy) gq.push_back(guess);
    if (done) done_cnt++;
  end

  function automatic int model_iters(input int t);
    int lo = 0, hi = 65535, g, n = 0;
    while (n < 40) begin
      g = lo + (hi - lo) / 2;
      n++;
      if (t == g) return n;
      if (t > g) lo = g + 1; else hi = g - 1;
    end
    return n;
  endfunction

  task automatic launch();
    gq.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic observe(output res_t got, output int c, output logic pulse_ok);
    c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
    end
    got = {found, err, result, iter_count};
    @(negedge clk);
    start = 1'b0;
    pulse_ok = !done && !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({guess, busy, done, found, err, result, iter_count} !== '0) begin
      fails++;
      $display("FAIL reset: guess=%0d busy=%b done=%b found=%b err=%b result=%0d iter=%0d want all 0",
               guess, busy, done, found, err, result, iter_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_mid();
    res_t got, e; int c; logic p;
    target = 16'd32767; mode = 0;
    sb.push_back('{1'b1, 1'b0, 16'd32767, 5'd1});
    launch();
    tests++;
    if (guess !== 16'd32767 || busy !== 1'b1) begin
      fails++; $display("FAIL mid_first_guess: guess=%0d busy=%b want 32767 1", guess, busy);
    end
    observe(got, c, p);
    e = sb.pop_front();
    tests++;
    if (got !== e) begin fails++; $display("FAIL mid_outcome: got %h want %h", got, e); end
    tests++;
    if (c !== 1 || p !== 1'b1) begin fails++; $display("FAIL mid_timing: latency %0d pulse_ok %b want 1 1", c, p); end
  endtask

  task automatic test_zero();
    res_t got, e; int c, bad; logic p;
    target = 16'd0; mode = 0;
    sb.push_back('{1'b1, 1'b0, 16'd0, 5'd16});
    launch();
    observe(got, c, p);
    e = sb.pop_front();
    tests++;
    if (got !== e) begin fails++; $display("FAIL zero_outcome: got %h want %h", got, e); end
    bad = (gq.size() != 16) ? 1 : 0;
    for (int k = 0; k < gq.size() && k < 16; k++)
      if (gq[k] !== ((k < 15) ? 16'((1 << (15 - k)) - 1) : 16'd0)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL zero_guess_seq: %0d bad entries, size %0d want 16", bad, gq.size()); end
  endtask

  task automatic test_max();
    res_t got, e; int c; logic p;
    target = 16'hFFFF; mode = 0;
    sb.push_back('{1'b1, 1'b0, 16'hFFFF, 5'd17});
    launch();
    observe(got, c, p);
    e = sb.pop_front();
    tests++;
    if (got !== e) begin fails++; $display("FAIL max_outcome: got %h want %h", got, e); end
    tests++;
    if (gq.size() != 17 || gq[$] !== 16'hFFFF || guess !== 16'hFFFF) begin
      fails++; $display("FAIL max_last_guess: n=%0d guess=%0d want 17 65535", gq.size(), guess);
    end
  endtask

  task automatic test_const_lt();
    res_t got, e; int c; logic p;
    mode = 1;
    sb.push_back('{1'b0, 1'b0, 16'd0, 5'd16});
    launch();
    observe(got, c, p);
    e = sb.pop_front();
    tests++;
    if (got !== e) begin fails++; $display("FAIL const_lt_outcome: got %h want %h", got, e); end
    tests++;
    if (guess !== 16'd0) begin fails++; $display("FAIL const_lt_last_guess: got %0d want 0", guess); end
    mode = 0;
  endtask

  task automatic test_illegal();
    res_t got, e; int c; logic p;
    mode = 2;
    sb.push_back('{1'b0, 1'b1, 16'd0, 5'd1});
    launch();
    observe(got, c, p);
    e = sb.pop_front();
    tests++;
    if (got !== e) begin fails++; $display("FAIL illegal_none: got %h want %h", got, e); end
    mode = 3; target = 16'd12345;
    sb.push_back('{1'b0, 1'b1, 16'd0, 5'd4});
    launch();
    observe(got, c, p);
    e = sb.pop_front();
    tests++;
    if (got !== e) begin fails++; $display("FAIL illegal_gt_lt: got %h want %h", got, e); end
    mode = 0;
  endtask

  task automatic test_start_held();
    res_t got, e; int c, n; logic p;
    target = 16'd1000; mode = 0;
    n = model_iters(1000);
    sb.push_back('{1'b1, 1'b0, 16'd1000, 5'(n)});
    gq.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    observe(got, c, p);
    e = sb.pop_front();
    tests++;
    if (got !== e || c !== n) begin fails++; $display("FAIL start_held_outcome: got %h lat %0d want %h lat %0d", got, c, e, n); end
    tests++;
    if (p !== 1'b1) begin fails++; $display("FAIL start_held_done_state: pulse_ok %b want 1", p); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_held_not_queued: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int d0;
    target = 16'd0; mode = 0;
    launch();
    repeat (4) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL reset_mid_busy: busy %b want 1", busy); end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({guess, busy, done, found, err, result, iter_count} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: guess=%0d busy=%b done=%b iter=%0d want all 0", guess, busy, done, iter_count);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid_no_done: done pulses %0d busy %b want 0 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_back_to_back();
    res_t got, e; int c, t; logic p;
    mode = 0;
    for (int i = 0; i < 5; i++) begin
      t = (i == 0) ? 777 : int'($urandom_range(0, 65535));
      target = 16'(t);
      sb.push_back('{1'b1, 1'b0, 16'(t), 5'(model_iters(t))});
      launch();
      observe(got, c, p);
      e = sb.pop_front();
      tests++;
      if (got !== e || c !== int'(e.iter) || p !== 1'b1) begin
        fails++; $display("FAIL back_to_back[%0d]: got %h lat %0d pulse_ok %b want %h", i, got, c, p, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mid();
    test_zero();
    test_max();
    test_const_lt();
    test_illegal();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Sequential binary-search initiator that drives the `b` side of the team's 16-bit magnitude comparator and consumes its `gt`/`lt`/`eq` flags. It locates an unknown 16-bit target value sitting on the comparator's `a` input. The search takes one comparison per clock and reports the located value through a start/busy/done handshake. It serves as the controller for threshold-discovery and calibration paths, where the target is only observable through a compare.

## Interface

Parameters:
- `WIDTH`, default 16. Width of `guess` and `result`, and the compared quantity.

Ports:
- `clk`  in  1  Rising-edge clock; the only clock in the block.
- `rst`  in  1  Reset, synchronous and active-high.
- `start`  in  1  Begins a search. Sampled only in IDLE.
- `cmp_gt`  in  1  Comparator flag: target > `guess`.
- `cmp_lt`  in  1  Comparator flag: target < `guess`.
- `cmp_eq`  in  1  Comparator flag: target == `guess`.
- `guess`  out  WIDTH  Registered value driven to the comparator `b` input.
- `busy`  out  1  High while in SEARCH.
- `done`  out  1  One-cycle pulse when a search ends.
- `found`  out  1  Search ended on `cmp_eq`. Valid with `done`; held until the next start.
- `err`  out  1  Illegal flag combination seen. Valid with `done`; held until the next start.
- `result`  out  WIDTH  Located value. Valid with `done`; held until the next start.
- `iter_count`  out  5  Number of comparisons consumed. Held until the next start.

## Operation

- States: IDLE, SEARCH, DONE.
- Reset, any state, any cycle: the next state is IDLE. All outputs go to 0, including `guess`. Internal bounds go to `lo=0` and `hi=2^WIDTH-1`. A reset during SEARCH abandons the search with no `done` pulse.
- IDLE:
  - `start=1` loads `lo=0`, `hi=2^WIDTH-1` and `guess=lo+((hi-lo)>>1)` (32767 for WIDTH=16).
  - It also clears `found`, `err`, `result` and `iter_count`, then moves to SEARCH.
- SEARCH, once per cycle:
  - Sample the flags and increment `iter_count`.
  - Exactly one flag set, `cmp_eq`: set `found=1` and `result=guess`, then go to DONE.
  - Exactly one flag set, `cmp_gt`: if `guess==hi`, end not-found and go to DONE. Otherwise set `lo=guess+1`.
  - Exactly one flag set, `cmp_lt`: if `guess==lo`, end not-found and go to DONE. Otherwise set `hi=guess-1`.
  - Zero flags set, or more than one: set `err=1` and `found=0`, then go to DONE.
  - Otherwise compute the new `guess=lo'+((hi'-lo')>>1)` from the updated bounds and stay in SEARCH.
- DONE: assert `done` for exactly one cycle, then return to IDLE.
- `start` is ignored in SEARCH and DONE. It is never queued.
- Arithmetic:
  - Midpoint computed in WIDTH+1 bits so no intermediate overflows.
  - `guess+1` and `guess-1` are never committed at 2^WIDTH-1 and 0 respectively; the end-of-range checks run first.
  - `lo<=guess<=hi` holds in every SEARCH cycle.
- Bound: a search ends in at most WIDTH+1 comparisons (17 for WIDTH=16). `iter_count` never exceeds WIDTH+1.
- On a not-found end, `result` is 0 and `found`=0, `err`=0.

## Timing

- Edge E0 samples `start` in IDLE.
- `guess` is valid and `busy`=1 from E0 until the search-ending edge.
- Comparator is combinational. Flags are sampled at each rising edge in SEARCH, one edge after the corresponding `guess` change.
- A search using N comparisons:
  - SEARCH occupies N cycles.
  - `done` is high in cycle N+1 after E0.
  - `busy` falls in the same cycle `done` rises.
- A new `start` is accepted no earlier than the cycle after the `done` pulse, i.e. back in IDLE. Turnaround is 2 cycles from `done` to the next first comparison.
- `guess` holds its last value in DONE and IDLE.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Test plan

- Target 32767, comparator model attached, `start` pulse:
  - required: first guess 32767, `cmp_eq` taken;
  - `done` one cycle after the first compare, `found`=1, `result`=32767, `iter_count`=1.
- Target 0:
  - required: guesses are 32767, 16383, …, 1, 0;
  - ends with `found`=1, `result`=0, `iter_count`=16.
- Target 65535:
  - required: 17 comparisons, last guess 65535;
  - ends with `found`=1, `iter_count`=17, no overflow of `guess`.
- Flags forced to constant `cmp_lt`=1:
  - required: the guess sequence reaches 0 and the search ends not-found;
  - `found`=0, `err`=0, `iter_count`=16.
- Illegal flags:
  - all flags 0 on the first compare: `err`=1, `iter_count`=1;
  - `cmp_gt`=`cmp_lt`=1 mid-search: `err`=1 at that iteration.
- Control edge cases:
  - `start` held high throughout: `start` is ignored during SEARCH and DONE;
  - `rst` asserted on the 5th SEARCH cycle: next cycle IDLE, all outputs 0, no `done` pulse;
  - a fresh search after that reset completes correctly.
